ram8_seq: RTL

//  8-word sequential register bank, the load-side consumer of dmux8way.
//  A write handshake's load strobe is routed by dmux8way to exactly one word register.

---
 rtl/hack_pkg.sv | 14 +
 rtl/dmux8way.sv | 31 +++
 rtl/ram8_seq.sv | 84 ++++++++
 3 files changed

// File: rtl/hack_pkg.sv
// Shared Hack-platform types: word and 8-way address widths, RAM8 sequencer states.
package hack_pkg;

    localparam int unsigned WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [2:0]        addr8_t;

    typedef enum logic {
        IDLE,
        CLEAR
    } ram_seq_state_t;

endpackage

// File: rtl/dmux8way.sv
// 1-to-8 demultiplexer: routes in to the output selected by sel (0 -> a ... 7 -> h).
module dmux8way (
    input  logic       in,
    input  logic [2:0] sel,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       h
);

    // case matching is exact, so a select with any X/Z bit leaves every output low
    always_comb begin
        {a, b, c, d, e, f, g, h} = '0;
        case (sel)
            3'd0: a = in;
            3'd1: b = in;
            3'd2: c = in;
            3'd3: d = in;
            3'd4: e = in;
            3'd5: f = in;
            3'd6: g = in;
            3'd7: h = in;
            default: ;
        endcase
    end

endmodule

// File: rtl/ram8_seq.sv
// 8-word register bank with valid/ready write port, registered read port and
// a self-timed sequencer that clears one word per cycle.
module ram8_seq
    import hack_pkg::*;
#(
    parameter int unsigned      WIDTH     = WORD_W,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [2:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             clr_req,
    output logic             busy
);

    ram_seq_state_t   state;
    logic [2:0]       clr_cnt;
    logic [WIDTH-1:0] mem [8];
    logic [7:0]       ld;
    logic             fire;

    assign wr_ready = (state == IDLE);
    assign busy     = (state == CLEAR);
    assign fire     = wr_valid & wr_ready;

    dmux8way u_dmux (
        .in  (fire),
        .sel (wr_addr),
        .a   (ld[0]),
        .b   (ld[1]),
        .c   (ld[2]),
        .d   (ld[3]),
        .e   (ld[4]),
        .f   (ld[5]),
        .g   (ld[6]),
        .h   (ld[7])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 3'd1;
                    if (clr_cnt == 3'd7) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Clear and write never coincide: loads only fire while IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) mem[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (state == CLEAR && clr_cnt == 3'(i))
                    mem[i] <= CLR_VALUE;
                else if (ld[i])
                    mem[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= mem[rd_addr];
    end

endmodule
